// File: rtl/buffer_seq_pkg.sv
// rtl/buffer_seq_pkg.sv - step codes and issue-FSM states shared by the sequencer and the 40-bit shift buffer
package buffer_seq_pkg;

    localparam logic [3:0] INIT_P    = 4'd0;
    localparam logic [3:0] UINIT1_P  = 4'd2;
    localparam logic [3:0] UINIT2_P  = 4'd3;
    localparam logic [3:0] INIT_U    = 4'd4;
    localparam logic [3:0] UINIT1_U  = 4'd6;
    localparam logic [3:0] UINIT2_U  = 4'd7;
    localparam logic [3:0] END3      = 4'd8;
    localparam logic [3:0] END4      = 4'd9;
    localparam logic [3:0] IDLE_CODE = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_UINIT1,
        ST_UINIT2,
        ST_END3,
        ST_END4,
        ST_FLUSH
    } seq_state_e;

endpackage

// File: rtl/step_delay_line.sv
// rtl/step_delay_line.sv - DEPTH-stage delay of {step code, row_last}, aligning codes with line-memory read data
module step_delay_line
    import buffer_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned W     = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] code_i,
    input  logic         last_i,
    output logic [W-1:0] code_o,
    output logic         last_o
);

    logic [W-1:0] code_q [DEPTH];
    logic         last_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                code_q[i] <= W'(IDLE_CODE);
                last_q[i] <= 1'b0;
            end
        end else begin
            code_q[0] <= code_i;
            last_q[0] <= last_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                code_q[i] <= code_q[i-1];
                last_q[i] <= last_q[i-1];
            end
        end
    end

    assign code_o = code_q[DEPTH-1];
    assign last_o = last_q[DEPTH-1];

endmodule

// File: rtl/buffer_shift_seq.sv
// rtl/buffer_shift_seq.sv - step-code sequencer for the per-MAC 40-bit shift buffer
// Optional config rejection under BUFFER_SEQ_CFG_CHECK_EN.
module buffer_shift_seq
    import buffer_seq_pkg::*;
#(
    parameter int unsigned X_MAC      = 4,
    parameter int unsigned MUXCONTROL = 4,
    parameter int unsigned WORD_CNT_W = 10,
    parameter int unsigned ROW_CNT_W  = 10,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    ready,
    input  logic                    pad,
    input  logic [WORD_CNT_W-1:0]   cfg_words,
    input  logic [ROW_CNT_W-1:0]    cfg_rows,
    input  logic [$clog2(X_MAC):0]  cfg_active_mac,
    input  logic [X_MAC*2-1:0]      cfg_mux,
    input  logic                    pause,
    output logic                    rd_en,
    output logic [MUXCONTROL-1:0]   control,
    output logic [X_MAC*2-1:0]      buffermux,
    output logic [X_MAC-1:0]        iszero,
    output logic                    row_last,
    output logic                    done,
    output logic                    err
);

    localparam int unsigned A_W = $clog2(X_MAC) + 1;

    seq_state_e              state_q, state_d;
    logic [WORD_CNT_W-1:0]   k_q, k_d;
    logic [ROW_CNT_W-1:0]    rows_q, rows_d;
    logic [2:0]              cnt_q, cnt_d;
    logic                    done_q, done_d;
    logic                    pad_q;
    logic [WORD_CNT_W-1:0]   words_q;
    logic [X_MAC*2-1:0]      mux_q;
    logic [X_MAC-1:0]        mask_q, mask_d;

    logic                    accept;
    logic [WORD_CNT_W-1:0]   words_eff;
    logic [ROW_CNT_W-1:0]    rows_eff;
    logic [A_W-1:0]          act_eff;
    logic [MUXCONTROL-1:0]   code_d;
    logic                    last_d;
    logic                    row_end;

    assign ready = (state_q == ST_IDLE);

`ifdef BUFFER_SEQ_CFG_CHECK_EN
    logic cfg_bad;
    logic err_q;

    assign cfg_bad   = (cfg_words == '0) || (cfg_rows == '0) || (cfg_active_mac > A_W'(X_MAC));
    assign accept    = ready && start && !cfg_bad;
    assign words_eff = cfg_words;
    assign rows_eff  = cfg_rows;
    assign act_eff   = cfg_active_mac;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (ready && start && cfg_bad) begin
            err_q <= 1'b1;
        end
    end
    assign err = err_q;
`else
    assign accept    = ready && start;
    assign words_eff = (cfg_words == '0) ? WORD_CNT_W'(1) : cfg_words;
    assign rows_eff  = (cfg_rows == '0) ? ROW_CNT_W'(1) : cfg_rows;
    assign act_eff   = (cfg_active_mac > A_W'(X_MAC)) ? A_W'(X_MAC) : cfg_active_mac;
    assign err       = 1'b0;
`endif

    always_comb begin
        mask_d = '0;
        for (int j = 0; j < int'(X_MAC); j++) begin
            mask_d[j] = (j >= int'(act_eff));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            rows_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            pad_q   <= 1'b0;
            words_q <= '0;
            mux_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            rows_q  <= rows_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            if (accept) begin
                pad_q   <= pad;
                words_q <= words_eff;
                mux_q   <= cfg_mux;
                mask_q  <= mask_d;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        rows_d  = rows_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        code_d  = MUXCONTROL'(IDLE_CODE);
        last_d  = 1'b0;
        rd_en   = 1'b0;
        row_end = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_INIT;
                    rows_d  = rows_eff;
                end
            end
            ST_INIT: begin
                if (!pause) begin
                    code_d = MUXCONTROL'(pad_q ? INIT_P : INIT_U);
                    rd_en  = 1'b1;
                    k_d    = WORD_CNT_W'(1);
                    if (words_q == WORD_CNT_W'(1)) begin
                        if (pad_q) state_d = ST_END3;
                        else       row_end = 1'b1;
                    end else begin
                        state_d = ST_UINIT1;
                    end
                end
            end
            ST_UINIT1: begin
                if (!pause) begin
                    code_d  = MUXCONTROL'(pad_q ? UINIT1_P : UINIT1_U);
                    rd_en   = 1'b1;
                    state_d = ST_UINIT2;
                end
            end
            ST_UINIT2: begin
                // word k is held on din this cycle, so no read is issued
                if (!pause) begin
                    code_d = MUXCONTROL'(pad_q ? UINIT2_P : UINIT2_U);
                    k_d    = k_q + WORD_CNT_W'(1);
                    if (({1'b0, k_q} + (WORD_CNT_W+1)'(1)) < {1'b0, words_q}) begin
                        state_d = ST_UINIT1;
                    end else if (pad_q) begin
                        state_d = ST_END3;
                    end else begin
                        row_end = 1'b1;
                    end
                end
            end
            ST_END3: begin
                if (!pause) begin
                    code_d  = MUXCONTROL'(END3);
                    state_d = ST_END4;
                end
            end
            ST_END4: begin
                if (!pause) begin
                    code_d  = MUXCONTROL'(END4);
                    row_end = 1'b1;
                end
            end
            ST_FLUSH: begin
                // let the last codes drain out of the delay line before signalling completion
                if (cnt_q == 3'(RD_LAT - 1)) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (row_end) begin
            last_d = 1'b1;
            if (rows_q > ROW_CNT_W'(1)) begin
                rows_d  = rows_q - ROW_CNT_W'(1);
                state_d = ST_INIT;
            end else begin
                rows_d  = '0;
                cnt_d   = '0;
                state_d = ST_FLUSH;
            end
        end
    end

    step_delay_line #(
        .DEPTH (RD_LAT),
        .W     (MUXCONTROL)
    ) u_step_delay_line (
        .clk    (clk),
        .rst_n  (rst_n),
        .code_i (code_d),
        .last_i (last_d),
        .code_o (control),
        .last_o (row_last)
    );

    assign buffermux = mux_q;
    assign iszero    = mask_q;
    assign done      = done_q;

endmodule

// File: tb/tb_buffer_shift_seq.sv
// tb/tb_buffer_shift_seq.sv - directed self-checking bench for buffer_shift_seq
module tb_buffer_shift_seq;
    import buffer_seq_pkg::*;

    localparam int X_MAC = 4;
    localparam int MUXCONTROL = 4;
    localparam int WORD_CNT_W = 10;
    localparam int ROW_CNT_W = 10;
    localparam int RD_LAT = 1;
    localparam int MAXS = 64;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic                   ready;
    logic                   pad = 1'b0;
    logic [WORD_CNT_W-1:0]  cfg_words = '0;
    logic [ROW_CNT_W-1:0]   cfg_rows = '0;
    logic [2:0]             cfg_active_mac = '0;
    logic [7:0]             cfg_mux = '0;
    logic                   pause = 1'b0;
    logic                   rd_en;
    logic [3:0]             control;
    logic [7:0]             buffermux;
    logic [3:0]             iszero;
    logic                   row_last;
    logic                   done;
    logic                   err;

    buffer_shift_seq #(
        .X_MAC(X_MAC), .MUXCONTROL(MUXCONTROL), .WORD_CNT_W(WORD_CNT_W),
        .ROW_CNT_W(ROW_CNT_W), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .pad(pad),
        .cfg_words(cfg_words), .cfg_rows(cfg_rows), .cfg_active_mac(cfg_active_mac),
        .cfg_mux(cfg_mux), .pause(pause), .rd_en(rd_en), .control(control),
        .buffermux(buffermux), .iszero(iszero), .row_last(row_last), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    logic [3:0] seq [$];
    logic [3:0] exp_q [$];
    int first_idx, last_idx, done_at, done_cnt, rd_cnt, rl_cnt, rl_last, hold_bad;
    logic [6:0] rd_bits;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_len"}, seq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < seq.size()) check($sformatf("%s_code%0d", tag, i), seq[i], exp_q[i]);
        end
    endtask

    task automatic run_job(input logic p, input int L, input int R, input int A,
                           input logic [7:0] mux, input int pause_at, input int pause_len,
                           input int busy_at, input logic [3:0] exp_iz);
        @(negedge clk);
        pad = p; cfg_words = WORD_CNT_W'(L); cfg_rows = ROW_CNT_W'(R);
        cfg_active_mac = 3'(A); cfg_mux = mux; start = 1'b1;
        seq.delete();
        first_idx = -1; last_idx = -1; done_at = -1; done_cnt = 0;
        rd_cnt = 0; rl_cnt = 0; rl_last = -1; hold_bad = 0; rd_bits = '0;
        for (int s = 0; s < MAXS; s++) begin
            @(posedge clk);
            #1;
            if (s == 0) start = 1'b0;
            pause = (s >= pause_at) && (s < pause_at + pause_len);
            if (s == busy_at) begin
                start = 1'b1; cfg_mux = 8'h00; cfg_active_mac = 3'd4; pad = ~p;
            end else if (s == busy_at + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
            if (control !== 4'hF) begin
                seq.push_back(control);
                if (first_idx < 0) first_idx = s;
                last_idx = s;
            end
            if (rd_en) rd_cnt++;
            if (s < 7) rd_bits[s] = rd_en;
            if (row_last) begin rl_cnt++; rl_last = s; end
            if (iszero !== exp_iz || buffermux !== mux) hold_bad++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = s;
            end
            if (done_at >= 0 && s >= done_at + 3) break;
        end
        pause = 1'b0;
        start = 1'b0;
        if (done_at < 0) check("done_timeout", 0, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_control", control, 4'hF);
        check("rst_rd_en", rd_en, 0);
        check("rst_row_last", row_last, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ready", ready, 1);
        check("rst_buffermux", buffermux, 0);
        check("rst_iszero", iszero, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // padded, L=3, one row
        run_job(1'b1, 3, 1, 4, 8'h1B, -1, 0, -1, 4'b0000);
        exp_q = '{4'd0, 4'd2, 4'd3, 4'd2, 4'd3, 4'd8, 4'd9};
        check_seq("p3");
        check("p3_first", first_idx, 1);
        check("p3_rd_bits", rd_bits, 7'b0001011);
        check("p3_rd_cnt", rd_cnt, 3);
        check("p3_row_last_at", rl_last, 7);
        check("p3_done_at", done_at, 8);
        check("p3_done_cnt", done_cnt, 1);
        check("p3_ready", ready, 1);

        // unpadded, L=2, two rows back to back
        run_job(1'b0, 2, 2, 4, 8'h1B, -1, 0, -1, 4'b0000);
        exp_q = '{4'd4, 4'd6, 4'd7, 4'd4, 4'd6, 4'd7};
        check_seq("u2r2");
        check("u2r2_span", last_idx - first_idx, 5);
        check("u2r2_rd_cnt", rd_cnt, 4);
        check("u2r2_row_last_cnt", rl_cnt, 2);

        // single-word rows
        run_job(1'b1, 1, 1, 4, 8'h1B, -1, 0, -1, 4'b0000);
        exp_q = '{4'd0, 4'd8, 4'd9};
        check_seq("p1");
        check("p1_done_at", done_at, 4);
        run_job(1'b0, 1, 1, 4, 8'h1B, -1, 0, -1, 4'b0000);
        exp_q = '{4'd4};
        check_seq("u1");
        check("u1_row_last_at", rl_last, 1);
        check("u1_done_at", done_at, 2);

        // pause for 3 cycles mid-row
        run_job(1'b1, 4, 1, 4, 8'h1B, 2, 3, -1, 4'b0000);
        exp_q = '{4'd0, 4'd2, 4'd3, 4'd2, 4'd3, 4'd2, 4'd3, 4'd8, 4'd9};
        check_seq("pause");
        check("pause_span", last_idx - first_idx, 11);
        check("pause_done_at", done_at, 13);
        check("pause_rd_cnt", rd_cnt, 4);

        // column masking / routing held, start while busy ignored
        run_job(1'b1, 2, 1, 2, 8'hE4, -1, 0, 2, 4'b1100);
        exp_q = '{4'd0, 4'd2, 4'd3, 4'd8, 4'd9};
        check_seq("mux");
        check("mux_hold_bad", hold_bad, 0);
        check("mux_iszero", iszero, 4'b1100);
        check("mux_done_cnt", done_cnt, 1);

        // reset mid-job
        @(negedge clk);
        pad = 1'b1; cfg_words = 10'd4; cfg_rows = 10'd3; cfg_active_mac = 3'd1;
        cfg_mux = 8'hA5; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mrst_control", control, 4'hF);
        check("mrst_rd_en", rd_en, 0);
        check("mrst_row_last", row_last, 0);
        check("mrst_ready", ready, 1);
        check("mrst_iszero", iszero, 0);
        check("mrst_buffermux", buffermux, 0);
        @(negedge clk) rst_n = 1'b1;
        done_cnt = 0; rd_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (rd_en) rd_cnt++;
        end
        check("mrst_no_done", done_cnt, 0);
        check("mrst_no_rd", rd_cnt, 0);

`ifdef BUFFER_SEQ_CFG_CHECK_EN
        @(negedge clk);
        pad = 1'b1; cfg_words = 10'd0; cfg_rows = 10'd1; cfg_active_mac = 3'd4; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        rd_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rd_en) rd_cnt++;
        end
        check("chk_err", err, 1);
        check("chk_no_rd", rd_cnt, 0);
        check("chk_ready", ready, 1);
`else
        run_job(1'b0, 1, 1, 7, 8'h3C, -1, 0, -1, 4'b0000);
        exp_q = '{4'd4};
        check_seq("a7");
        check("a7_iszero", iszero, 0);
        run_job(1'b1, 0, 0, 4, 8'h3C, -1, 0, -1, 4'b0000);
        exp_q = '{4'd0, 4'd8, 4'd9};
        check_seq("l0r0");
        check("l0r0_err", err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
